// File: rtl/dmem_arbiter_if.sv
// Single-master data-port bundle: request side driven by the master,
// grant and read return driven by the arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          req;
  logic [3:0]    we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data RAM arbiter with 1-cycle read return routing.
// Define ARB_ROUND_ROBIN_EN for fair tie-break + MAX_HOLD tenure limit.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rstn,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          mem_en_o,
  output logic [3:0]    mem_wr_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic [1:0]    owner_o
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic          gnt0, gnt1;
  logic          at_max;
  logic          same_owner;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q=1: m1 was granted most recently, so m0 wins the next idle tie
  logic          last_q, last_d;
`endif

  assign at_max = (hold_q >= HW'(MAX_HOLD));

  // Grant decision, next owner and tenure count
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d = last_q;
    unique case (state_q)
      OWN0: begin
        if (m0.req && (!m1.req || !at_max)) gnt0 = 1'b1;
        else if (m1.req)                     gnt1 = 1'b1;
      end
      OWN1: begin
        if (m1.req && (!m0.req || !at_max)) gnt1 = 1'b1;
        else if (m0.req)                     gnt0 = 1'b1;
      end
      default: begin
        if (m0.req && (!m1.req || last_q)) gnt0 = 1'b1;
        else if (m1.req)                    gnt1 = 1'b1;
      end
    endcase
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
`else
    gnt0 = m0.req;
    gnt1 = !m0.req && m1.req;
`endif
    same_owner = (gnt0 && state_q == OWN0) ||
                 (gnt1 && state_q == OWN1);
    state_d = IDLE;
    hold_d  = '0;
    if (gnt0) state_d = OWN0;
    if (gnt1) state_d = OWN1;
    if (same_owner)       hold_d = at_max ? hold_q : hold_q + 1'b1;
    else if (gnt0 | gnt1) hold_d = HW'(1);
    rv0_d = gnt0 && (m0.we == 4'b0000);
    rv1_d = gnt1 && (m1.we == 4'b0000);
  end

  // Memory-side mux of the granted master
  always_comb begin
    mem_en_o    = 1'b0;
    mem_wr_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      gnt0: begin
        mem_en_o    = 1'b1;
        mem_wr_o    = m0.we;
        mem_addr_o  = m0.addr;
        mem_wdata_o = m0.wdata;
      end
      gnt1: begin
        mem_en_o    = 1'b1;
        mem_wr_o    = m1.we;
        mem_addr_o  = m1.addr;
        mem_wdata_o = m1.wdata;
      end
      default: ;
    endcase
  end

  // Owner, tenure and read-return state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rv0_q;
  assign m1.rvalid = rv1_q;
  assign m0.rdata  = mem_rdata_i;
  assign m1.rdata  = mem_rdata_i;
  assign owner_o   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a policy-level model.
// Build with ARB_ROUND_ROBIN_EN to exercise the fair mode.
module tb_dmem_arbiter;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32)) m0_if ();
  dmem_arbiter_if #(.AW(32)) m1_if ();

  logic        mem_en;
  logic [3:0]  mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  owner;

  dmem_arbiter #(.AW(32), .MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .m0          (m0_if),
    .m1          (m1_if),
    .mem_en_o    (mem_en),
    .mem_wr_o    (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .owner_o     (owner)
  );

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  // RAM environment: 1-cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr == 4'b0000)
        mem_rdata <= env_mem[mem_addr[9:2]];
      else
        for (int b = 0; b < 4; b++)
          if (mem_wr[b])
            env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  bit          act [2];
  logic [3:0]  twe [2];
  logic [31:0] tad [2];
  logic [31:0] twd [2];

  int          st;
  int          run;
  int          lastm;
  bit          prv [2];
  logic [31:0] prd [2];

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    bit r0 = act[0];
    bit r1 = act[1];
`ifdef ARB_ROUND_ROBIN_EN
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (st == 0) return (lastm == 0) ? 1 : 0;
    if (run < MAXH) return st - 1;
    return 2 - st;
`else
    if (r0) return 0;
    if (r1) return 1;
    return -1;
`endif
  endfunction

  task automatic reset_model();
    st    = 0;
    run   = 0;
    lastm = 1;
    prv   = '{0, 0};
    act   = '{0, 0};
  endtask

  task automatic newtx(input int m, input bit rd);
    act[m] = 1'b1;
    if (rd || $urandom_range(0, 1) == 0) twe[m] = 4'b0000;
    else twe[m] = 4'($urandom_range(1, 15));
    tad[m] = {22'b0, 8'($urandom), 2'b00};
    twd[m] = $urandom;
  endtask

  task automatic step();
    int g;
    int ix;
    m0_if.req   = act[0];
    m0_if.we    = twe[0];
    m0_if.addr  = tad[0];
    m0_if.wdata = twd[0];
    m1_if.req   = act[1];
    m1_if.we    = twe[1];
    m1_if.addr  = tad[1];
    m1_if.wdata = twd[1];
    @(negedge clk);
    g = pick();
    chk("owner", 32'(owner), 32'(st));
    chk("gnt0", 32'(m0_if.gnt), 32'(g == 0));
    chk("gnt1", 32'(m1_if.gnt), 32'(g == 1));
    chk("mem_en", 32'(mem_en), 32'(g >= 0));
    chk("mem_wr", 32'(mem_wr), (g >= 0) ? 32'(twe[g]) : 32'd0);
    if (g >= 0) begin
      chk("mem_addr", mem_addr, tad[g]);
      if (twe[g] != 4'b0000) chk("mem_wdata", mem_wdata, twd[g]);
    end
    chk("rvalid0", 32'(m0_if.rvalid), 32'(prv[0]));
    chk("rvalid1", 32'(m1_if.rvalid), 32'(prv[1]));
    if (prv[0]) chk("rdata0", m0_if.rdata, prd[0]);
    if (prv[1]) chk("rdata1", m1_if.rdata, prd[1]);
    prv = '{0, 0};
    if (g >= 0) begin
      ix = int'(tad[g][9:2]);
      if (twe[g] == 4'b0000) begin
        prv[g] = 1'b1;
        prd[g] = ref_mem[ix];
      end else begin
        for (int b = 0; b < 4; b++)
          if (twe[g][b]) ref_mem[ix][8*b +: 8] = twd[g][8*b +: 8];
      end
      act[g] = 1'b0;
      if (st == g + 1) run = (run < MAXH) ? run + 1 : run;
      else run = 1;
      st    = g + 1;
      lastm = g;
    end else begin
      st  = 0;
      run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'hC0DE0000 ^ (i * 32'h01030507);
      ref_mem[i] = 32'hC0DE0000 ^ (i * 32'h01030507);
    end
    twe = '{4'b0, 4'b0};
    tad = '{32'b0, 32'b0};
    twd = '{32'b0, 32'b0};
    reset_model();
    m0_if.req = 1'b0; m0_if.we = '0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.we = '0; m1_if.addr = '0; m1_if.wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_rv0", 32'(m0_if.rvalid), 32'd0);
    chk("rst_rv1", 32'(m1_if.rvalid), 32'd0);
    chk("rst_men", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    act[0] = 1'b1; twe[0] = 4'b0000; tad[0] = 32'h10; twd[0] = $urandom;
    step();
    step();

    act[1] = 1'b1; twe[1] = 4'b0001; tad[1] = 32'h400; twd[1] = 32'hA5;
    step();
    step();

    act[0] = 1'b1; twe[0] = 4'b0000; tad[0] = 32'h20;
    step();
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_owner", 32'(owner), 32'd0);
    chk("mid_rv0", 32'(m0_if.rvalid), 32'd0);
    chk("mid_men", 32'(mem_en), 32'd0);
    reset_model();
    @(posedge clk);
    #1 rstn = 1'b1;
    step();

    for (int c = 0; c < 12; c++) begin
      for (int m = 0; m < 2; m++) if (!act[m]) newtx(m, 1'b0);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      if (!act[1]) newtx(1, 1'b0);
      step();
    end
    for (int c = 0; c < 10 && (act[0] || act[1]); c++) step();

    for (int c = 0; c < 10; c++) begin
      act[c % 2] = 1'b1;
      twe[c % 2] = 4'b0000;
      tad[c % 2] = (c % 2 == 1) ? 32'h4 : 32'h0;
      step();
    end
    step();

    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++)
        if (!act[m] && $urandom_range(0, 2) != 0) newtx(m, 1'b0);
      step();
    end
    for (int c = 0; c < 20 && (act[0] || act[1]); c++) step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
